// File: rtl/wakeup_cam_rdy.sv
// wakeup_cam_rdy: issue-queue wakeup CAM with per-entry valid and sticky ready.
// Each IQ entry holds one source-operand physical tag. Wakeup broadcasts are
// matched against all entries. Dispatch writes may pick up a same-cycle
// broadcast through a bypass compare.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   tag_i/tagValid_i  RPORT wakeup broadcasts (port p at [p*WIDTH +: WIDTH])
//   vect_o            combinational per-port match vectors (port p at [p*DEPTH +: DEPTH])
//   we_i/addrwr_i/datawr_i/rdywr_i  WPORT dispatch write ports
//   clr_i             per-entry invalidate (issue/free)
//   flush_i           invalidate all entries
//   valid_o/ready_o   registered entry state
//   count_o           registered number of valid entries
//   err_o             only with WAKEUP_CAM_ALLOC_CHECK_EN: sticky allocation error
//
// Optional feature macro: WAKEUP_CAM_ALLOC_CHECK_EN
module wakeup_cam_rdy #(
  parameter int unsigned RPORT = 4,
  parameter int unsigned WPORT = 4,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned INDEX = 5,
  parameter int unsigned WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [RPORT*WIDTH-1:0] tag_i,
  input  logic [RPORT-1:0]       tagValid_i,
  output logic [RPORT*DEPTH-1:0] vect_o,
  input  logic [WPORT-1:0]       we_i,
  input  logic [WPORT*INDEX-1:0] addrwr_i,
  input  logic [WPORT*WIDTH-1:0] datawr_i,
  input  logic [WPORT-1:0]       rdywr_i,
  input  logic [DEPTH-1:0]       clr_i,
  input  logic                   flush_i,
  output logic [DEPTH-1:0]       valid_o,
  output logic [DEPTH-1:0]       ready_o,
  output logic [INDEX:0]         count_o
`ifdef WAKEUP_CAM_ALLOC_CHECK_EN
  ,
  output logic                   err_o
`endif
);

  localparam int unsigned CW = INDEX + 1;

  logic [WIDTH-1:0] ram [DEPTH];

  logic [DEPTH-1:0] hit_any;
  logic [WPORT-1:0] byp;
  logic [DEPTH-1:0] wr_hit;
  logic [DEPTH-1:0] wr_rdy;
  logic [WIDTH-1:0] wr_data [DEPTH];
  logic [DEPTH-1:0] valid_nxt;
  logic [DEPTH-1:0] ready_nxt;
  logic [CW-1:0]    count_nxt;

  // CAM match against current state only
  always_comb begin
    vect_o  = '0;
    hit_any = '0;
    for (int unsigned p = 0; p < RPORT; p++) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        vect_o[p*DEPTH + e] = tagValid_i[p] & valid_o[e] &
                              (ram[e] == tag_i[p*WIDTH +: WIDTH]);
        hit_any[e] = hit_any[e] | vect_o[p*DEPTH + e];
      end
    end
  end

  // Dispatch bypass: incoming tag already broadcast this cycle
  always_comb begin
    byp = '0;
    for (int unsigned w = 0; w < WPORT; w++) begin
      for (int unsigned p = 0; p < RPORT; p++) begin
        if (tagValid_i[p] && (tag_i[p*WIDTH +: WIDTH] == datawr_i[w*WIDTH +: WIDTH])) begin
          byp[w] = 1'b1;
        end
      end
    end
  end

  // Write decode; ascending loop lets the highest-numbered port win
  always_comb begin
    wr_hit = '0;
    wr_rdy = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      wr_data[e] = '0;
    end
    for (int unsigned w = 0; w < WPORT; w++) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (we_i[w] && (addrwr_i[w*INDEX +: INDEX] == INDEX'(e))) begin
          wr_hit[e]  = 1'b1;
          wr_rdy[e]  = rdywr_i[w] | byp[w];
          wr_data[e] = datawr_i[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Per-entry next state: flush > write > clear > wakeup > hold
  always_comb begin
    valid_nxt = valid_o;
    ready_nxt = ready_o;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (flush_i) begin
        valid_nxt[e] = 1'b0;
        ready_nxt[e] = 1'b0;
      end else if (wr_hit[e]) begin
        valid_nxt[e] = 1'b1;
        ready_nxt[e] = wr_rdy[e];
      end else if (clr_i[e]) begin
        valid_nxt[e] = 1'b0;
        ready_nxt[e] = 1'b0;
      end else if (valid_o[e] && hit_any[e]) begin
        ready_nxt[e] = 1'b1;
      end
    end
  end

  // Population count of next valid vector
  always_comb begin
    count_nxt = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      count_nxt = count_nxt + CW'(valid_nxt[e]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_o <= '0;
      ready_o <= '0;
      count_o <= '0;
    end else begin
      valid_o <= valid_nxt;
      ready_o <= ready_nxt;
      count_o <= count_nxt;
    end
  end

  // Tag storage is deliberately not reset
  always_ff @(posedge clk) begin
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (!flush_i && wr_hit[e]) begin
        ram[e] <= wr_data[e];
      end
    end
  end

`ifdef WAKEUP_CAM_ALLOC_CHECK_EN
  logic [DEPTH-1:0] wr_multi;
  logic             err_nxt;

  // Two or more write ports targeting the same entry
  always_comb begin
    wr_multi = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      int unsigned n;
      n = 0;
      for (int unsigned w = 0; w < WPORT; w++) begin
        if (we_i[w] && (addrwr_i[w*INDEX +: INDEX] == INDEX'(e))) begin
          n = n + 1;
        end
      end
      wr_multi[e] = (n > 1);
    end
  end

  // Allocation errors; flush cycles are exempt
  always_comb begin
    err_nxt = 1'b0;
    if (!flush_i) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if ((wr_hit[e] && valid_o[e] && !clr_i[e]) ||
            (clr_i[e] && !valid_o[e]) || wr_multi[e]) begin
          err_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_o <= 1'b0;
    end else if (err_nxt) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wakeup_cam_rdy.sv
// tb_wakeup_cam_rdy: directed vectors with hand-computed expectations.
// Stimulus pushes expected values tagged with the cycle they apply to; a
// monitor checks them at the falling edge of that cycle.
module tb_wakeup_cam_rdy;

  localparam int unsigned RPORT = 4;
  localparam int unsigned WPORT = 4;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned INDEX = 5;
  localparam int unsigned WIDTH = 7;

  localparam int K_VALID = 0;
  localparam int K_READY = 1;
  localparam int K_COUNT = 2;
  localparam int K_VECT  = 3;
  localparam int K_ERR   = 4;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [RPORT*WIDTH-1:0] tag_i = '0;
  logic [RPORT-1:0]       tag_valid = '0;
  logic [RPORT*DEPTH-1:0] vect_o;
  logic [WPORT-1:0]       we_i = '0;
  logic [WPORT*INDEX-1:0] addrwr_i = '0;
  logic [WPORT*WIDTH-1:0] datawr_i = '0;
  logic [WPORT-1:0]       rdywr_i = '0;
  logic [DEPTH-1:0]       clr_i = '0;
  logic                   flush_i = 1'b0;
  logic [DEPTH-1:0]       valid_o;
  logic [DEPTH-1:0]       ready_o;
  logic [INDEX:0]         count_o;
`ifdef WAKEUP_CAM_ALLOC_CHECK_EN
  logic                   err_o;
`endif

  wakeup_cam_rdy #(
    .RPORT(RPORT), .WPORT(WPORT), .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tag_i     (tag_i),
    .tagValid_i(tag_valid),
    .vect_o    (vect_o),
    .we_i      (we_i),
    .addrwr_i  (addrwr_i),
    .datawr_i  (datawr_i),
    .rdywr_i   (rdywr_i),
    .clr_i     (clr_i),
    .flush_i   (flush_i),
    .valid_o   (valid_o),
    .ready_o   (ready_o),
    .count_o   (count_o)
`ifdef WAKEUP_CAM_ALLOC_CHECK_EN
    ,
    .err_o     (err_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] actual(input int kind, input int idx);
    case (kind)
      K_VALID: return valid_o;
      K_READY: return ready_o;
      K_COUNT: return 32'(count_o);
      K_VECT:  return vect_o[idx*DEPTH +: DEPTH];
`ifdef WAKEUP_CAM_ALLOC_CHECK_EN
      K_ERR:   return 32'(err_o);
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Expectation for this cycle (dly=0, combinational) or next (dly=1, registered)
  task automatic expect_val(input int kind, input int idx, input logic [31:0] v,
                            input string name, input int dly);
    chk_t c;
    c.at = cyc + dly; c.kind = kind; c.idx = idx; c.exp = v; c.name = name;
    q.push_back(c);
  endtask

  // Monitor: compare every expectation that falls due this cycle
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].at <= cyc) begin
        chk_t c;
        logic [31:0] a;
        c = q.pop_front();
        n_vec++;
        if (c.at < cyc) begin
          n_fail++;
          $display("FAIL %s: check missed (due cycle %0d, now %0d)", c.name, c.at, cyc);
        end else begin
          a = actual(c.kind, c.idx);
          if (a !== c.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", c.name, a, c.exp, cyc);
          end
        end
      end
    end
  end

  task automatic idle();
    tag_i = '0; tag_valid = '0; we_i = '0; addrwr_i = '0;
    datawr_i = '0; rdywr_i = '0; clr_i = '0; flush_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic bcast(input int p, input logic [WIDTH-1:0] t);
    tag_i[p*WIDTH +: WIDTH] = t;
    tag_valid[p] = 1'b1;
  endtask

  task automatic wr(input int w, input int e, input logic [WIDTH-1:0] t, input logic r);
    we_i[w] = 1'b1;
    addrwr_i[w*INDEX +: INDEX] = INDEX'(e);
    datawr_i[w*WIDTH +: WIDTH] = t;
    rdywr_i[w] = r;
  endtask

  initial begin
    // 1. Reset with random inputs
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      tag_i = 28'($urandom); tag_valid = 4'($urandom); we_i = 4'($urandom);
      addrwr_i = 20'($urandom); datawr_i = 28'($urandom); rdywr_i = 4'($urandom);
      clr_i = $urandom; flush_i = 1'($urandom);
    end
    step();
    reset_n = 1'b1;
    bcast(0, 7'h15);
    bcast(1, 7'h00);
    expect_val(K_VALID, 0, 32'h0, "rst_valid", 0);
    expect_val(K_READY, 0, 32'h0, "rst_ready", 0);
    expect_val(K_COUNT, 0, 32'd0, "rst_count", 0);
    expect_val(K_VECT,  0, 32'h0, "rst_vect0", 0);
    expect_val(K_VECT,  1, 32'h0, "rst_vect1", 0);
`ifdef WAKEUP_CAM_ALLOC_CHECK_EN
    expect_val(K_ERR,   0, 32'd0, "rst_err", 0);
`endif

    // 2. Dispatch e3 tag 0x15 not ready, wake it a cycle later on p2
    step();
    wr(0, 3, 7'h15, 1'b0);
    expect_val(K_VALID, 0, 32'h0000_0008, "disp_valid", 1);
    expect_val(K_READY, 0, 32'h0000_0000, "disp_ready", 1);
    expect_val(K_COUNT, 0, 32'd1, "disp_count", 1);
    step();
    bcast(2, 7'h15);
    expect_val(K_VECT,  2, 32'h0000_0008, "wake_vect2", 0);
    expect_val(K_VECT,  0, 32'h0000_0000, "wake_vect0", 0);
    expect_val(K_READY, 0, 32'h0000_0008, "wake_ready", 1);
    expect_val(K_COUNT, 0, 32'd1, "wake_count", 1);

    // 3. Bypass: write e7 tag 0x2A while p0 broadcasts 0x2A
    step();
    wr(1, 7, 7'h2A, 1'b0);
    bcast(0, 7'h2A);
    expect_val(K_VECT,  0, 32'h0000_0000, "byp_vect0", 0);
    expect_val(K_VALID, 0, 32'h0000_0088, "byp_valid", 1);
    expect_val(K_READY, 0, 32'h0000_0088, "byp_ready", 1);
    expect_val(K_COUNT, 0, 32'd2, "byp_count", 1);

    // 4. w0 and w3 both write e5; w3 wins
    step();
    wr(0, 5, 7'h01, 1'b0);
    wr(3, 5, 7'h02, 1'b0);
    expect_val(K_VALID, 0, 32'h0000_00A8, "conf_valid", 1);
    expect_val(K_READY, 0, 32'h0000_0088, "conf_ready", 1);
    expect_val(K_COUNT, 0, 32'd3, "conf_count", 1);
`ifdef WAKEUP_CAM_ALLOC_CHECK_EN
    expect_val(K_ERR,   0, 32'd1, "conf_err", 1);
`endif
    step();
    bcast(1, 7'h02);
    bcast(3, 7'h01);
    expect_val(K_VECT,  1, 32'h0000_0020, "conf_vect1", 0);
    expect_val(K_VECT,  3, 32'h0000_0000, "conf_vect3", 0);
    expect_val(K_READY, 0, 32'h0000_00A8, "conf_wake", 1);

    // Same tag on two ports wakes once
    step();
    wr(2, 10, 7'h40, 1'b0);
    expect_val(K_VALID, 0, 32'h0000_04A8, "dup_valid", 1);
    expect_val(K_READY, 0, 32'h0000_00A8, "dup_ready0", 1);
    expect_val(K_COUNT, 0, 32'd4, "dup_count0", 1);
    step();
    bcast(0, 7'h40);
    bcast(1, 7'h40);
    expect_val(K_VECT,  0, 32'h0000_0400, "dup_vect0", 0);
    expect_val(K_VECT,  1, 32'h0000_0400, "dup_vect1", 0);
    expect_val(K_READY, 0, 32'h0000_04A8, "dup_ready1", 1);
    expect_val(K_COUNT, 0, 32'd4, "dup_count1", 1);

    // 5. Fill all entries (ready at dispatch), tag = 0x50 + entry
    for (int k = 0; k < 8; k++) begin
      step();
      for (int w = 0; w < 4; w++) wr(w, 4*k + w, 7'(8'h50 + 8'(4*k + w)), 1'b1);
    end
    expect_val(K_VALID, 0, 32'hFFFF_FFFF, "fill_valid", 1);
    expect_val(K_READY, 0, 32'hFFFF_FFFF, "fill_ready", 1);
    expect_val(K_COUNT, 0, 32'd32, "fill_count", 1);
    // Write to a full queue overwrites, count stays at the maximum
    step();
    wr(0, 4, 7'h11, 1'b0);
    expect_val(K_READY, 0, 32'hFFFF_FFEF, "full_ready", 1);
    expect_val(K_COUNT, 0, 32'd32, "full_count", 1);
    step();
    clr_i = 32'h0000_00FF;
    bcast(3, 7'h64);
    expect_val(K_VECT,  3, 32'h0010_0000, "clr_vect3", 0);
    expect_val(K_VALID, 0, 32'hFFFF_FF00, "clr_valid", 1);
    expect_val(K_READY, 0, 32'hFFFF_FF00, "clr_ready", 1);
    expect_val(K_COUNT, 0, 32'd24, "clr_count", 1);
    step();
    flush_i = 1'b1;
    wr(0, 0, 7'h12, 1'b1);
    bcast(0, 7'h70);
    expect_val(K_VALID, 0, 32'h0, "flush_valid", 1);
    expect_val(K_READY, 0, 32'h0, "flush_ready", 1);
    expect_val(K_COUNT, 0, 32'd0, "flush_count", 1);

    // 6. Clear and rewrite e9 in the same cycle
    step();
    wr(0, 9, 7'h33, 1'b1);
    expect_val(K_VALID, 0, 32'h0000_0200, "e9_valid0", 1);
    expect_val(K_COUNT, 0, 32'd1, "e9_count0", 1);
    step();
    clr_i = 32'h0000_0200;
    wr(0, 9, 7'h33, 1'b0);
    expect_val(K_VALID, 0, 32'h0000_0200, "realloc_valid", 1);
    expect_val(K_READY, 0, 32'h0000_0000, "realloc_ready", 1);
    expect_val(K_COUNT, 0, 32'd1, "realloc_count", 1);
    step();
    bcast(0, 7'h33);
    expect_val(K_VECT,  0, 32'h0000_0200, "realloc_vect", 0);
    expect_val(K_READY, 0, 32'h0000_0200, "realloc_wake", 1);
    step();
    expect_val(K_READY, 0, 32'h0000_0200, "sticky_ready", 1);
    step();
    clr_i = 32'h0000_0200;
    expect_val(K_VALID, 0, 32'h0, "final_valid", 1);
    expect_val(K_READY, 0, 32'h0, "final_ready", 1);
    expect_val(K_COUNT, 0, 32'd0, "final_count", 1);
    step();

    // Drain with a bound
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    while (q.size() > 0) begin
      chk_t c;
      c = q.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL %s: never checked (due cycle %0d)", c.name, c.at);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
